branch_predictor_ctrl: RTL and testbench

- Dynamic branch predictor and mispredict controller for the 5-stage RISC-V pipeline.
- Looks up a table of 2-bit saturating counters with the decode-stage PC and tells the decode stage whether to steer fetch to the branch target.
- Tracks each prediction through to execute, compares it with the resolved outcome, and raises redirect/flush requests on a mispredict.
- After reset, sequences a table-initialisation sweep and exposes performance counters.

---
 rtl/branch_predictor_ctrl.sv | 132 +++++++++++++
 tb/tb_branch_predictor_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor_ctrl.sv
// Two-bit saturating-counter branch predictor with a decode->execute shadow of
// each prediction, mispredict detection, a post-reset table sweep and perf counters.
module branch_predictor_ctrl #(
  parameter int         INDEX_BITS = 6,
  parameter logic [1:0] CNT_INIT   = 2'b01,
  parameter int         PERF_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       PCD,
  input  logic              BranchD,
  output logic              PredictTakenD,
  input  logic              FlushE,
  input  logic              TakenE,
  output logic              MispredictE,
  output logic              RedirectTakenE,
  output logic              FlushReq,
  output logic              Ready,
  output logic [PERF_W-1:0] BranchCount,
  output logic [PERF_W-1:0] MissCount
);

  localparam int DEPTH = 1 << INDEX_BITS;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t                  state_q;
  logic [INDEX_BITS-1:0]   ptr_q;
  logic                    ready_q;
  logic                    valid_q;
  logic                    pred_q;
  logic [INDEX_BITS-1:0]   idx_q;
  logic [PERF_W-1:0]       bc_q, bc_d;
  logic [PERF_W-1:0]       mc_q, mc_d;

  logic [1:0]              cnt_tbl_q [DEPTH];
  logic [INDEX_BITS-1:0]   idx_d;
  logic [1:0]              cnt_e;
  logic [1:0]              cnt_upd_d;
  logic                    tbl_we;
  logic [INDEX_BITS-1:0]   tbl_waddr;
  logic [1:0]              tbl_wdata;
  logic                    pcd_unused;

  assign idx_d      = PCD[INDEX_BITS+1:2];
  assign pcd_unused = ^{PCD[31:INDEX_BITS+2], PCD[1:0]};

  // Lookup sees the pre-update counter; a same-index update lands at the edge.
  assign PredictTakenD  = (state_q == S_RUN) & BranchD & cnt_tbl_q[idx_d][1];
  assign MispredictE    = valid_q & (pred_q ^ TakenE);
  assign RedirectTakenE = MispredictE & TakenE;
  assign FlushReq       = MispredictE;
  assign Ready          = ready_q;
  assign BranchCount    = bc_q;
  assign MissCount      = mc_q;

  assign cnt_e = cnt_tbl_q[idx_q];

  always_comb begin
    cnt_upd_d = cnt_e;
    if (TakenE) begin
      if (cnt_e != 2'b11) cnt_upd_d = cnt_e + 2'b01;
    end else begin
      if (cnt_e != 2'b00) cnt_upd_d = cnt_e - 2'b01;
    end
  end

  always_comb begin
    bc_d = bc_q;
    mc_d = mc_q;
    if (bc_q != '1) bc_d = bc_q + 1'b1;
    if (MispredictE && (mc_q != '1)) mc_d = mc_q + 1'b1;
  end

  // One write port shared by the init sweep and the execute-stage training update.
  always_comb begin
    tbl_we    = 1'b0;
    tbl_waddr = ptr_q;
    tbl_wdata = CNT_INIT;
    if (state_q == S_INIT) begin
      tbl_we = 1'b1;
    end else if (valid_q) begin
      tbl_we    = 1'b1;
      tbl_waddr = idx_q;
      tbl_wdata = cnt_upd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (tbl_we) cnt_tbl_q[tbl_waddr] <= tbl_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_INIT;
      ptr_q   <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      pred_q  <= 1'b0;
      idx_q   <= '0;
      bc_q    <= '0;
      mc_q    <= '0;
    end else begin
      case (state_q)
        S_INIT: begin
          ptr_q   <= ptr_q + 1'b1;
          valid_q <= 1'b0;
          if (ptr_q == '1) begin
            state_q <= S_RUN;
            ready_q <= 1'b1;
          end
        end
        S_RUN: begin
          // A flush kills only the incoming capture; the resolving branch still counts.
          if (FlushE) begin
            valid_q <= 1'b0;
          end else begin
            valid_q <= BranchD;
            pred_q  <= PredictTakenD;
            idx_q   <= idx_d;
          end
          if (valid_q) begin
            bc_q <= bc_d;
            mc_q <= mc_d;
          end
        end
        default: state_q <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_predictor_ctrl.sv
// Directed bench for branch_predictor_ctrl: a spec-level model checked every cycle
// plus hand-computed pin checks along the training/flush/reset scenarios.
module tb_branch_predictor_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] PCD = 32'h0;
  logic        BranchD = 1'b0;
  logic        FlushE = 1'b0;
  logic        TakenE = 1'b0;
  logic        PredictTakenD, MispredictE, RedirectTakenE, FlushReq, Ready;
  logic [15:0] BranchCount, MissCount;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  branch_predictor_ctrl #(.INDEX_BITS(6), .CNT_INIT(2'b01), .PERF_W(16)) dut (
    .clk(clk), .rst(rst), .PCD(PCD), .BranchD(BranchD), .PredictTakenD(PredictTakenD),
    .FlushE(FlushE), .TakenE(TakenE), .MispredictE(MispredictE),
    .RedirectTakenE(RedirectTakenE), .FlushReq(FlushReq), .Ready(Ready),
    .BranchCount(BranchCount), .MissCount(MissCount)
  );

  always #5 clk = ~clk;

  // Spec-level model: table of small integers, sweep as a cycle count.
  int m_tbl [64];
  int m_sweep = 0;
  bit m_valid = 1'b0;
  bit m_pred  = 1'b0;
  int m_idx   = 0;
  int m_bc    = 0;
  int m_mc    = 0;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % 64);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_sweep <= 0;
      m_valid <= 1'b0;
      m_bc    <= 0;
      m_mc    <= 0;
    end else if (m_sweep < 64) begin
      if (m_sweep == 63) for (int i = 0; i < 64; i++) m_tbl[i] <= 1;
      m_sweep <= m_sweep + 1;
      m_valid <= 1'b0;
    end else begin
      if (m_valid) begin
        if (TakenE) m_tbl[m_idx] <= (m_tbl[m_idx] >= 3) ? 3 : m_tbl[m_idx] + 1;
        else        m_tbl[m_idx] <= (m_tbl[m_idx] <= 0) ? 0 : m_tbl[m_idx] - 1;
        m_bc <= (m_bc >= 65535) ? 65535 : m_bc + 1;
        if (m_pred != TakenE) m_mc <= (m_mc >= 65535) ? 65535 : m_mc + 1;
      end
      if (FlushE) begin
        m_valid <= 1'b0;
      end else begin
        m_valid <= BranchD;
        m_pred  <= BranchD && (m_tbl[idx_of(PCD)] >= 2);
        m_idx   <= idx_of(PCD);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      logic run, e_pred, e_mis;
      run    = (m_sweep >= 64);
      e_pred = run && BranchD && (m_tbl[idx_of(PCD)] >= 2);
      e_mis  = m_valid && (m_pred != TakenE);
      chk("m_pred",     {31'b0, PredictTakenD},  {31'b0, e_pred});
      chk("m_mis",      {31'b0, MispredictE},    {31'b0, e_mis});
      chk("m_redirect", {31'b0, RedirectTakenE}, {31'b0, e_mis && TakenE});
      chk("m_flushreq", {31'b0, FlushReq},       {31'b0, e_mis});
      chk("m_ready",    {31'b0, Ready},          {31'b0, run});
      chk("m_bc",       {16'b0, BranchCount},    m_bc);
      chk("m_mc",       {16'b0, MissCount},      m_mc);
    end
  end

  task automatic step(input logic [31:0] pc, input logic br, input logic fl, input logic tk);
    @(posedge clk);
    #1;
    PCD = pc; BranchD = br; FlushE = fl; TakenE = tk;
    @(negedge clk);
  endtask

  task automatic sweep_check(input string tag);
    for (int k = 1; k <= 64; k++) begin
      step(32'h100, (k < 64), 1'b0, 1'b0);
      chk({tag, "_ready"}, {31'b0, Ready}, (k == 64) ? 32'd1 : 32'd0);
      if (k < 64) chk({tag, "_pred_init"}, {31'b0, PredictTakenD}, 32'd0);
    end
    $display("%s: sweep done, Ready=%0b", tag, Ready);
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish (errors=%0d)", n_err);
    $fatal(1, "timeout");
  end

  initial begin
    #2 rst = 1'b0;
    #1;
    chk_en = 1'b1;
    chk("rst_ready", {31'b0, Ready}, 32'd0);
    chk("rst_bc", {16'b0, BranchCount}, 32'd0);
    chk("rst_mc", {16'b0, MissCount}, 32'd0);
    chk("rst_pred", {31'b0, PredictTakenD}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    sweep_check("init");

    // Default prediction then first mispredict (counter 01 -> 10)
    step(32'h100, 1, 0, 0); chk("def_pred", {31'b0, PredictTakenD}, 32'd0);
    step(32'h0,   0, 0, 1); chk("def_mis", {31'b0, MispredictE}, 32'd1);
    chk("def_redir", {31'b0, RedirectTakenE}, 32'd1);
    chk("def_flushreq", {31'b0, FlushReq}, 32'd1);
    $display("default: pred=0 then mispredict taken");

    // Training: three more taken resolves (10 -> 11 -> 11 -> 11)
    for (int i = 0; i < 3; i++) begin
      step(32'h100, 1, 0, 0); chk("trn_pred", {31'b0, PredictTakenD}, 32'd1);
      chk("trn_bc", {16'b0, BranchCount}, 32'(1 + i));
      step(32'h0, 0, 0, 1); chk("trn_mis", {31'b0, MispredictE}, 32'd0);
    end
    step(32'h100, 1, 0, 0); chk("nt_pred", {31'b0, PredictTakenD}, 32'd1);
    step(32'h0,   0, 0, 0); chk("nt_mis", {31'b0, MispredictE}, 32'd1);
    chk("nt_redir", {31'b0, RedirectTakenE}, 32'd0);
    step(32'h100, 1, 0, 0); chk("nt_pred_after", {31'b0, PredictTakenD}, 32'd1);
    chk("nt_bc", {16'b0, BranchCount}, 32'd5);
    chk("nt_mc", {16'b0, MissCount}, 32'd2);
    step(32'h0, 0, 0, 1); chk("nt_resolve", {31'b0, MispredictE}, 32'd0);
    $display("training: bc=%0d mc=%0d", BranchCount, MissCount);

    // Aliasing: 0x200 shares index 0 with 0x100 (counter now 11)
    step(32'h200, 1, 0, 0); chk("al_pred", {31'b0, PredictTakenD}, 32'd1);
    step(32'h200, 1, 0, 0); chk("al_same_cycle_old", {31'b0, PredictTakenD}, 32'd1);
    chk("al_mis", {31'b0, MispredictE}, 32'd1);
    step(32'h100, 0, 0, 0); chk("al_mis2", {31'b0, MispredictE}, 32'd1);
    step(32'h100, 1, 0, 0); chk("al_pred_trained", {31'b0, PredictTakenD}, 32'd0);
    chk("al_bc", {16'b0, BranchCount}, 32'd8);
    chk("al_mc", {16'b0, MissCount}, 32'd4);
    step(32'h0, 0, 0, 0);
    $display("aliasing: bc=%0d mc=%0d", BranchCount, MissCount);

    // Flush kill: capture suppressed, nothing resolves
    step(32'h100, 1, 1, 0);
    step(32'h0,   0, 0, 1); chk("fk_mis", {31'b0, MispredictE}, 32'd0);
    chk("fk_bc", {16'b0, BranchCount}, 32'd9);
    // Flush coinciding with a valid resolve: still counted, no double resolve
    step(32'h100, 1, 0, 0); chk("fk_bc2", {16'b0, BranchCount}, 32'd9);
    step(32'h0,   0, 1, 1); chk("fr_mis", {31'b0, MispredictE}, 32'd1);
    step(32'h100, 1, 0, 1); chk("fr_nodouble", {31'b0, MispredictE}, 32'd0);
    chk("fr_bc", {16'b0, BranchCount}, 32'd10);
    chk("fr_mc", {16'b0, MissCount}, 32'd5);
    step(32'h0,   0, 0, 1);
    step(32'h100, 1, 0, 0); chk("fr_pred", {31'b0, PredictTakenD}, 32'd1);
    step(32'h0,   0, 0, 1);
    $display("flush: bc=%0d mc=%0d", BranchCount, MissCount);

    // Async reset mid-run with the entry trained to 11
    step(32'h100, 1, 0, 0); chk("ar_pred_before", {31'b0, PredictTakenD}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("ar_pred", {31'b0, PredictTakenD}, 32'd0);
    chk("ar_ready", {31'b0, Ready}, 32'd0);
    chk("ar_bc", {16'b0, BranchCount}, 32'd0);
    chk("ar_mis", {31'b0, MispredictE}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    sweep_check("resweep");
    step(32'h100, 1, 0, 0); chk("ar_pred_after", {31'b0, PredictTakenD}, 32'd0);

    // Saturation of BranchCount
    for (int i = 0; i < 65540; i++) step(32'h100, 1, 0, 1);
    step(32'h0, 0, 0, 0);
    chk("sat_bc", {16'b0, BranchCount}, 32'hFFFF);
    chk("sat_mc", {16'b0, MissCount}, 32'd2);
    for (int i = 0; i < 3; i++) step(32'h100, 1, 0, 1);
    step(32'h0, 0, 0, 0);
    chk("sat_bc_hold", {16'b0, BranchCount}, 32'hFFFF);
    $display("saturation: bc=%0h mc=%0d", BranchCount, MissCount);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
